serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits (>= 2).
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 clk  input  1  rising-edge clock; one clock domain only.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-006 a  input  WIDTH  minuend; captured only when start is accepted.
REQ-007 b  input  WIDTH  subtrahend; captured only when start is accepted.
REQ-008 borrow_in  input  1  initial borrow into bit 0; captured only when start is accepted.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking valid results.
REQ-011 diff  output  WIDTH  result a - b - borrow_in, modulo 2^WIDTH.
REQ-012 borrow_out  output  1  borrow out of the MSB; 1 when unsigned a < b + borrow_in.
REQ-013 zero  output  1  high when diff == 0.
REQ-014 overflow  output  1  two's-complement signed overflow of the subtraction.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE or DONE with start=1, the block SHALL capture a, b and borrow_in, clear the digit counter, and enter RUN on that edge.
REQ-017 start SHALL be ignored while in RUN; captured operands SHALL NOT change during RUN.
REQ-018 Each RUN cycle SHALL process the next DIGIT bits, LSB digit first, through a DIGIT-bit ripple borrow chain; the carried borrow SHALL be registered between digits.
REQ-019 After N = WIDTH/DIGIT RUN cycles, the FSM SHALL enter DONE; DONE SHALL last exactly one cycle, then return to IDLE unless start is accepted.
REQ-020 busy SHALL equal 1 exactly in RUN; done SHALL equal 1 exactly in DONE.
REQ-021 Latency from the start-accepting edge to done=1 SHALL be N+1 cycles; back-to-back operations SHALL be possible with start asserted during DONE.
REQ-022 diff, borrow_out, zero and overflow SHALL update only on entry to DONE.
REQ-023 These outputs SHALL hold their values until the next DONE or reset.
REQ-024 overflow SHALL equal (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]), using the captured operands.
REQ-025 Partial results SHALL never be visible on diff during RUN.
REQ-026 Boundary: a == b with borrow_in=0 gives diff=0, zero=1, borrow_out=0.
REQ-027 Boundary: a=0, b=0, borrow_in=1 gives diff=all-ones, borrow_out=1.

Reset
REQ-028 While rst=1 the state SHALL be IDLE, busy=0, done=0, diff=0, borrow_out=0, zero=0, overflow=0, and the digit counter and internal borrow SHALL be 0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-030 The first start after reset deassertion SHALL be honoured on the first rising clk edge.

Structure
REQ-031 Package serial_sub_pkg SHALL hold the FSM state typedef and the derived constant N; parameter legality (WIDTH % DIGIT == 0) SHALL be checked at elaboration.
REQ-032 One sub-module, digit_subtractor, SHALL implement the DIGIT-bit combinational ripple of full-subtractor cells (inputs a, b, borrow; outputs diff, borrow).
REQ-033 The top SHALL hold the FSM, counter, operand shift registers and result registers.

Verification
REQ-034 WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, borrow_in=0 -> done 9 cycles after start; diff=0x1E, borrow_out=0, zero=0, overflow=0.
REQ-035 WIDTH=8, DIGIT=1: a=0x00, b=0x01 -> diff=0xFF, borrow_out=1, overflow=0; a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow_out=0.
REQ-036 WIDTH=8, DIGIT=4: a=0x10, b=0x0F, borrow_in=1 -> done 3 cycles after start; diff=0x00, zero=1, borrow_out=0.
REQ-037 start pulsed with new operands during RUN -> ignored; first result unchanged. start held in DONE -> second op accepted, second done N+1 cycles later.
REQ-038 rst asserted 3 cycles into RUN -> all outputs 0 immediately; no done pulse after release; next start completes normally.
REQ-039 Randomised WIDTH=16, DIGIT in {1,2,4,8,16}: 1000 operand pairs vs. reference model a-b-borrow_in for all four result outputs.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// Holds the FSM state encoding and the digit-count derivation used by the top.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;
    localparam int DIGIT_DEFAULT = 1;
    localparam int N_DEFAULT     = WIDTH_DEFAULT / DIGIT_DEFAULT;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // A one-digit operation still needs a 1-bit counter.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// DIGIT-bit combinational ripple of full-subtractor cells.
// Borrow ripples LSB to MSB; o_borrow is the borrow out of the top cell.
module digit_subtractor #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_borrow,
    output logic [DIGIT-1:0] o_diff,
    output logic             o_borrow
);

    logic [DIGIT:0] w_chain;

    assign w_chain[0] = i_borrow;

    for (genvar k = 0; k < DIGIT; k++) begin : g_cell
        assign o_diff[k]     = i_a[k] ^ i_b[k] ^ w_chain[k];
        assign w_chain[k+1]  = (~i_a[k] & i_b[k]) | (~(i_a[k] ^ i_b[k]) & w_chain[k]);
    end

    assign o_borrow = w_chain[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, DIGIT bits per cycle, LSB first.
// Results are published only on entry to DONE and held until the next DONE or reset.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DIGIT = DIGIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int N     = num_digits(WIDTH, DIGIT);
    localparam int CNT_W = cnt_bits(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (((WIDTH % DIGIT) != 0) || (WIDTH < 2)) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_last;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_borrow;
    logic [WIDTH-1:0]   r_acc;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;
    logic               r_zero;
    logic               r_overflow;
    logic [DIGIT-1:0]   w_d;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_acc_next;

    digit_subtractor #(.DIGIT(DIGIT)) u_digit (
        .i_a      (r_a_sh[DIGIT-1:0]),
        .i_b      (r_b_sh[DIGIT-1:0]),
        .i_borrow (r_borrow),
        .o_diff   (w_d),
        .o_borrow (w_borrow)
    );

    // New digit enters at the top; after N digits the LSB digit sits at bit 0.
    assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));
    assign w_last     = (r_state == ST_RUN) && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST) w_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_borrow     <= 1'b0;
            r_acc        <= '0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_zero       <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= borrow_in;
            r_acc    <= '0;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
        end else if (r_state == ST_RUN) begin
            r_cnt    <= r_cnt + 1'b1;
            r_a_sh   <= r_a_sh >> DIGIT;
            r_b_sh   <= r_b_sh >> DIGIT;
            r_borrow <= w_borrow;
            r_acc    <= w_acc_next;
            if (w_last) begin
                r_diff       <= w_acc_next;
                r_borrow_out <= w_borrow;
                r_zero       <= (w_acc_next == '0);
                r_overflow   <= (r_a_msb != r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign zero       = r_zero;
    assign overflow   = r_overflow;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at several WIDTH/DIGIT points.
// Index 0 of the 8-bit arrays is DIGIT=1, index 1 is DIGIT=4.
module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic       start8 [2];
    logic [7:0] a8     [2];
    logic [7:0] b8     [2];
    logic       bin8   [2];
    logic       busy8  [2];
    logic       done8  [2];
    logic [7:0] diff8  [2];
    logic       bo8    [2];
    logic       zero8  [2];
    logic       ov8    [2];
    logic [1:0] st8    [2];

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        bin16;
    logic        busy16 [5];
    logic        done16 [5];
    logic [15:0] diff16 [5];
    logic        bo16   [5];
    logic        zero16 [5];
    logic        ov16   [5];
    logic [1:0]  st16   [5];

    logic [7:0] exp_q[$];

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start8[0]), .a(a8[0]), .b(b8[0]),
        .borrow_in(bin8[0]), .busy(busy8[0]), .done(done8[0]), .diff(diff8[0]),
        .borrow_out(bo8[0]), .zero(zero8[0]), .overflow(ov8[0]), .dbg_state(st8[0])
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start8[1]), .a(a8[1]), .b(b8[1]),
        .borrow_in(bin8[1]), .busy(busy8[1]), .done(done8[1]), .diff(diff8[1]),
        .borrow_out(bo8[1]), .zero(zero8[1]), .overflow(ov8[1]), .dbg_state(st8[1])
    );

    for (genvar g = 0; g < 5; g++) begin : g_w16
        serial_subtractor #(.WIDTH(16), .DIGIT(1 << g)) u_dut (
            .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
            .borrow_in(bin16), .busy(busy16[g]), .done(done16[g]), .diff(diff16[g]),
            .borrow_out(bo16[g]), .zero(zero16[g]), .overflow(ov16[g]), .dbg_state(st16[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives start for one edge and returns at the following negedge.
    task automatic launch(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bin);
        a8[sel]     = a;
        b8[sel]     = b;
        bin8[sel]   = bin;
        start8[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8[sel] = 1'b0;
    endtask

    task automatic finish_op(input int sel, input int cyc0, input logic bo, input logic z,
                             input logic ov, input int lat, input string tag);
        int cyc;
        logic [7:0] exp_diff;
        cyc = cyc0;
        while (!done8[sel] && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        exp_diff = exp_q.pop_front();
        check({tag, "_lat"},  cyc,        lat);
        check({tag, "_diff"}, diff8[sel], exp_diff);
        check({tag, "_bo"},   bo8[sel],   bo);
        check({tag, "_zero"}, zero8[sel], z);
        check({tag, "_ov"},   ov8[sel],   ov);
    endtask

    task automatic do_op8(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] d, input logic bo, input logic z, input logic ov,
                          input int lat, input string tag);
        logic [7:0] prev;
        prev = diff8[sel];
        exp_q.push_back(d);
        launch(sel, a, b, bin);
        check({tag, "_busy"}, busy8[sel], 1'b1);
        check({tag, "_hold"}, diff8[sel], prev);
        finish_op(sel, 1, bo, z, ov, lat, tag);
    endtask

    initial begin
        int pulses;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 2; i++) begin
            start8[i] = 1'b0; a8[i] = '0; b8[i] = '0; bin8[i] = 1'b0;
        end
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  busy8[0], 1'b0);
        check("rst_done",  done8[0], 1'b0);
        check("rst_diff",  diff8[0], 8'h00);
        check("rst_bo",    bo8[0],   1'b0);
        check("rst_zero",  zero8[0], 1'b0);
        check("rst_ov",    ov8[0],   1'b0);
        check("rst_state", st8[0],   2'd0);
        rst = 1'b0;

        // First start right after reset release is honoured on the first edge.
        do_op8(0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0, 9, "basic");
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", done8[0], 1'b0);
        check("idle_state", st8[0],   2'd0);
        do_op8(0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 9, "neg");
        do_op8(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 9, "ovf");
        do_op8(0, 8'h77, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 9, "equal");
        do_op8(0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 9, "bin_wrap");
        do_op8(1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3, "d4_zero");
        do_op8(1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 3, "d4_ovf");

        // start with new operands during RUN must be ignored.
        exp_q.push_back(8'h1E);
        launch(0, 8'h5A, 8'h3C, 1'b0);
        @(posedge clk);
        @(negedge clk);
        launch(0, 8'h01, 8'h02, 1'b0);
        finish_op(0, 3, 1'b0, 1'b0, 1'b0, 9, "ign");

        // start held in DONE: second op accepted immediately.
        exp_q.push_back(8'h1F);
        launch(0, 8'h20, 8'h01, 1'b0);
        finish_op(0, 1, 1'b0, 1'b0, 1'b0, 9, "b2b");

        // Reset three cycles into RUN aborts with no later done.
        launch(0, 8'h5A, 8'h01, 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("abort_busy",  busy8[0], 1'b0);
        check("abort_done",  done8[0], 1'b0);
        check("abort_diff",  diff8[0], 8'h00);
        check("abort_bo",    bo8[0],   1'b0);
        check("abort_zero",  zero8[0], 1'b0);
        check("abort_ov",    ov8[0],   1'b0);
        check("abort_state", st8[0],   2'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done8[0]) pulses++;
        end
        check("abort_nodone", pulses, 0);
        do_op8(0, 8'h33, 8'h44, 1'b0, 8'hEF, 1'b1, 1'b0, 1'b0, 9, "after_abort");

        // Randomised 16-bit sweep across every legal DIGIT at once.
        for (int i = 0; i < 1000; i++) begin
            logic [16:0] r;
            logic        exp_ov;
            a16     = 16'($urandom_range(0, 65535));
            b16     = 16'($urandom_range(0, 65535));
            bin16   = 1'($urandom_range(0, 1));
            r       = {1'b0, a16} - {1'b0, b16} - 17'(bin16);
            exp_ov  = (a16[15] != b16[15]) && (r[15] != a16[15]);
            start16 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start16 = 1'b0;
            repeat (17) @(posedge clk);
            @(negedge clk);
            for (int g = 0; g < 5; g++) begin
                check($sformatf("r16_d%0d_diff_%0d", 1 << g, i), diff16[g], r[15:0]);
                check($sformatf("r16_d%0d_bo_%0d",   1 << g, i), bo16[g],   r[16]);
                check($sformatf("r16_d%0d_zero_%0d", 1 << g, i), zero16[g], (r[15:0] == 16'h0));
                check($sformatf("r16_d%0d_ov_%0d",   1 << g, i), ov16[g],   exp_ov);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
